fde_sequencer: RTL and testbench
================================

Name: fde_sequencer

Overview:
- Multi-cycle fetch-decode-execute controller for the 8-bit CPU.
- Fetches 16-bit instructions from a synchronous instruction memory, decodes them, reads two source registers from the register file, then drives the execute stage with opcode, operands and destination address for exactly one cycle per instruction.
- Handles start, halt, single-step, NOP and illegal opcodes; runs one instruction at a time, with no pipelining or hazards.

Parameters:
PC_W, 8, program-counter and instruction-memory address width; PC wraps modulo 2^PC_W.
CNT_W, 16, width of the retired-instruction counter; saturates at its maximum value.

Ports:
i_clk  input  1  clock
i_reset  input  1  asynchronous, active-low reset
i_start  input  1  pulse; starts the program from PC=0 when in IDLE or HALTED
i_step_mode  input  1  1 = pause after each instruction until i_step
i_step  input  1  pulse; releases one instruction while in step mode
i_halt_req  input  1  stop request, sampled in WB
o_imem_en  output  1  instruction-memory read enable
o_imem_addr  output  PC_W  instruction address (= PC)
i_imem_data  input  16  instruction word, valid the cycle after o_imem_en
o_rs1_add  output  4  register-file read address 1 (IR[7:4])
o_rs2_add  output  4  register-file read address 2 (IR[3:0])
i_rs1_data  input  8  combinational register-file read data 1
i_rs2_data  input  8  combinational register-file read data 2
o_opcode  output  4  opcode to the execute stage; 0 when not in EXEC
o_srcdata_1  output  8  operand 1 to the execute stage
o_srcdata_2  output  8  operand 2 to the execute stage
o_destadd  output  4  destination register address (IR[11:8])
o_busy  output  1  1 in FETCH/DECODE/READ/EXEC/WB/STEP_WAIT
o_halted  output  1  1 in HALTED
o_illegal  output  1  sticky; set by an illegal opcode, cleared by i_start
o_pc  output  PC_W  current PC
o_instr_cnt  output  CNT_W  retired-instruction count

Behaviour:
- Reset: state IDLE; PC=0; IR=0; operands=0; o_opcode=0; o_destadd=0; o_imem_en=0; o_busy=0; o_halted=0; o_illegal=0; o_instr_cnt=0. Reset mid-instruction aborts immediately; no partial EXEC is issued afterwards.
- Instruction format: [15:12] opcode, [11:8] dest, [7:4] src1, [3:0] src2.
- Opcode classes:
  - ALU: 0001 ADD, 0010 SUB, 0100 LS, 1000 RS.
  - 0000 NOP.
  - 1111 HALT.
  - All other opcodes are illegal.
- States:
  - IDLE: o_busy=0. On i_start -> FETCH; PC=0, o_instr_cnt=0, o_illegal=0.
  - FETCH: o_imem_en=1, o_imem_addr=PC. Next state DECODE.
  - DECODE: IR <= i_imem_data at the end of the cycle. Next state READ.
  - READ: rs addresses driven from IR; operands latched from i_rs1/2_data at the end of the cycle. Next state:
    - ALU -> EXEC.
    - NOP -> WB.
    - HALT -> HALTED; PC and count unchanged.
    - Illegal -> set o_illegal, then WB (treated as NOP).
  - EXEC: for exactly one cycle, o_opcode=IR[15:12], o_srcdata_1/2=latched operands, o_destadd=IR[11:8]. These are registered outputs. Next state WB. o_opcode is 0 in every other state; o_srcdata and o_destadd hold their last values.
  - WB: one cycle for the execute stage's registered result to land. PC <= PC+1 (wraps to 0 after 2^PC_W-1); o_instr_cnt <= o_instr_cnt+1, saturating. Next-state priority:
    1. i_halt_req -> IDLE.
    2. i_step_mode -> STEP_WAIT.
    3. Otherwise -> FETCH.
  - STEP_WAIT: o_busy=1. i_step -> FETCH. If i_step_mode drops, -> FETCH.
  - HALTED: o_halted=1, o_busy=0. i_start -> FETCH with PC=0, count=0, o_illegal=0.
- Latency: ALU instruction 5 cycles (FETCH..WB); NOP or illegal 4 cycles; HALT 3 cycles to HALTED.
- i_start is ignored while o_busy=1. i_step is ignored outside STEP_WAIT. A simultaneous i_halt_req and i_step_mode in WB goes to IDLE.

Test Plan:
- Reset then i_start with imem[0]=0x1312 (ADD r3=r1+r2), r1=5, r2=7 -> exactly one EXEC cycle, 4 cycles after start, with o_opcode=1, o_srcdata_1=5, o_srcdata_2=7, o_destadd=3; o_pc=1 and o_instr_cnt=1 after WB.
- Program {0x2412, 0x0000, 0xF000} -> one SUB EXEC, NOP issues no EXEC (o_opcode stays 0), then HALTED with o_pc=2, o_instr_cnt=2, o_busy=0, o_halted=1.
- imem[0]=0x3000 (illegal) -> o_illegal=1, no EXEC, PC advances to 1; a later i_start clears o_illegal.
- i_step_mode=1 with three ALU instructions -> controller parks in STEP_WAIT after each; each i_step pulse yields exactly one EXEC; stray i_step pulses in other states have no effect.
- PC_W=2, four ADD words with no HALT -> PC sequence 0,1,2,3,0; o_instr_cnt=5 after five instructions.
- i_reset asserted during EXEC -> all outputs at reset values asynchronously; no EXEC until the next i_start.

Source files
------------

// File: rtl/fde_sequencer.sv
// Multi-cycle fetch-decode-execute controller: one instruction in flight, no pipelining.
// ALU 5 cycles, NOP/illegal 4 cycles, HALT 3 cycles to HALTED; only start/step/halt_req throttle it.
module fde_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic             i_halt_req,
    output logic             o_imem_en,
    output logic [PC_W-1:0]  o_imem_addr,
    input  logic [15:0]      i_imem_data,
    output logic [3:0]       o_rs1_add,
    output logic [3:0]       o_rs2_add,
    input  logic [7:0]       i_rs1_data,
    input  logic [7:0]       i_rs2_data,
    output logic [3:0]       o_opcode,
    output logic [7:0]       o_srcdata_1,
    output logic [7:0]       o_srcdata_2,
    output logic [3:0]       o_destadd,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_illegal,
    output logic [PC_W-1:0]  o_pc,
    output logic [CNT_W-1:0] o_instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_WB, S_STEP_WAIT, S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_LS   = 4'h4;
    localparam logic [3:0] OP_RS   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      ir_q, ir_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [7:0]       src1_q, src1_d;
    logic [7:0]       src2_q, src2_d;
    logic [3:0]       dest_q, dest_d;
    logic             illegal_q, illegal_d;
    logic             imem_en_q, imem_en_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic [3:0]       ir_op;

    assign ir_op = ir_q[15:12];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        opcode_d  = OP_NOP;
        src1_d    = src1_q;
        src2_d    = src2_q;
        dest_d    = dest_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (i_start) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    cnt_d     = '0;
                    illegal_d = 1'b0;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = i_imem_data;
                state_d = S_READ;
            end
            S_READ: begin
                case (ir_op)
                    OP_ADD, OP_SUB, OP_LS, OP_RS: begin
                        // EXEC outputs are loaded here so they are flops during EXEC.
                        state_d  = S_EXEC;
                        opcode_d = ir_op;
                        src1_d   = i_rs1_data;
                        src2_d   = i_rs2_data;
                        dest_d   = ir_q[11:8];
                    end
                    OP_NOP:  state_d = S_WB;
                    OP_HALT: state_d = S_HALTED;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_WB;
                    end
                endcase
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                pc_d = pc_q + PC_W'(1);
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (i_halt_req) begin
                    state_d = S_IDLE;
                end else if (i_step_mode) begin
                    state_d = S_STEP_WAIT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_STEP_WAIT: begin
                if (i_step || !i_step_mode) begin
                    state_d = S_FETCH;
                end
            end
        endcase

        imem_en_d = (state_d == S_FETCH);
        busy_d    = (state_d inside {S_FETCH, S_DECODE, S_READ, S_EXEC, S_WB, S_STEP_WAIT});
        halted_d  = (state_d == S_HALTED);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            ir_q      <= '0;
            opcode_q  <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            dest_q    <= '0;
            illegal_q <= 1'b0;
            imem_en_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            ir_q      <= ir_d;
            opcode_q  <= opcode_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            dest_q    <= dest_d;
            illegal_q <= illegal_d;
            imem_en_q <= imem_en_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    assign o_imem_en   = imem_en_q;
    assign o_imem_addr = pc_q;
    assign o_rs1_add   = ir_q[7:4];
    assign o_rs2_add   = ir_q[3:0];
    assign o_opcode    = opcode_q;
    assign o_srcdata_1 = src1_q;
    assign o_srcdata_2 = src2_q;
    assign o_destadd   = dest_q;
    assign o_busy      = busy_q;
    assign o_halted    = halted_q;
    assign o_illegal   = illegal_q;
    assign o_pc        = pc_q;
    assign o_instr_cnt = cnt_q;

endmodule

// File: tb/tb_fde_sequencer.sv
// Bench for fde_sequencer: program-level reference model feeds an EXEC scoreboard.
module tb_fde_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, step_mode, step, halt_req;
    logic        imem_en;
    logic [7:0]  imem_addr, pc;
    logic [15:0] imem_rd;
    logic [3:0]  rs1_add, rs2_add, opcode, destadd;
    logic [7:0]  rs1_data, rs2_data, src1, src2;
    logic        busy, halted, illegal;
    logic [15:0] instr_cnt;

    logic        start_b, halt_req_b;
    logic        imem_en_b;
    logic [1:0]  imem_addr_b, pc_b;
    logic [15:0] imem_rd_b;
    logic [3:0]  rs1_add_b, rs2_add_b, opcode_b, destadd_b;
    logic [7:0]  src1_b, src2_b;
    logic        busy_b, halted_b, illegal_b;
    logic [2:0]  instr_cnt_b;

    logic [15:0] imem   [256];
    logic [15:0] imem_b [4];
    logic [7:0]  regs   [16];

    always @(posedge clk) begin
        if (imem_en) imem_rd <= imem[imem_addr];
        if (imem_en_b) imem_rd_b <= imem_b[imem_addr_b];
    end
    assign rs1_data = regs[rs1_add];
    assign rs2_data = regs[rs2_add];

    fde_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_step_mode(step_mode),
        .i_step(step), .i_halt_req(halt_req), .o_imem_en(imem_en), .o_imem_addr(imem_addr),
        .i_imem_data(imem_rd), .o_rs1_add(rs1_add), .o_rs2_add(rs2_add),
        .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .o_opcode(opcode),
        .o_srcdata_1(src1), .o_srcdata_2(src2), .o_destadd(destadd), .o_busy(busy),
        .o_halted(halted), .o_illegal(illegal), .o_pc(pc), .o_instr_cnt(instr_cnt)
    );

    // Small instance: 2-bit PC and 3-bit counter make wrap and saturation cheap to reach.
    fde_sequencer #(.PC_W(2), .CNT_W(3)) dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_start(start_b), .i_step_mode(1'b0),
        .i_step(1'b0), .i_halt_req(halt_req_b), .o_imem_en(imem_en_b), .o_imem_addr(imem_addr_b),
        .i_imem_data(imem_rd_b), .o_rs1_add(rs1_add_b), .o_rs2_add(rs2_add_b),
        .i_rs1_data(regs[rs1_add_b]), .i_rs2_data(regs[rs2_add_b]), .o_opcode(opcode_b),
        .o_srcdata_1(src1_b), .o_srcdata_2(src2_b), .o_destadd(destadd_b), .o_busy(busy_b),
        .o_halted(halted_b), .o_illegal(illegal_b), .o_pc(pc_b), .o_instr_cnt(instr_cnt_b)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] d;
    } exec_t;

    exec_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    exec_seen = 0;
    int    n_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every EXEC cycle must match the oldest expected instruction.
    initial begin
        exec_t e;
        forever begin
            @(negedge clk);
            if (rst_n && opcode != 4'h0) begin
                exec_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_exec actual_opcode=0x%0h expected=no EXEC", opcode);
                end else begin
                    e = exp_q.pop_front();
                    chk("exec_tuple", 32'({opcode, src1, src2, destadd}), 32'(e));
                end
            end
        end
    end

    // Small instance: instruction k executes with PC = k mod 4 and count = min(k, 7).
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && opcode_b != 4'h0) begin
                chk("b_exec_opcode", 32'(opcode_b), 32'(1));
                chk("b_exec_pc", 32'(pc_b), 32'(n_b % 4));
                chk("b_exec_cnt", 32'(instr_cnt_b), 32'((n_b > 7) ? 7 : n_b));
                n_b++;
            end
        end
    end

    // Reference: walk the program word by word until HALT or max_instr retirements.
    task automatic model(input int max_instr, output int e_pc, output int e_cnt,
                         output logic e_ill, output logic e_halt);
        int pcm = 0;
        int n = 0;
        logic [15:0] w;
        logic [3:0]  op;
        e_ill  = 1'b0;
        e_halt = 1'b0;
        while (n < max_instr) begin
            w  = imem[pcm];
            op = w[15:12];
            if (op == 4'hF) begin
                e_halt = 1'b1;
                break;
            end
            if (op == 4'h1 || op == 4'h2 || op == 4'h4 || op == 4'h8)
                exp_q.push_back({op, regs[w[7:4]], regs[w[3:0]], w[11:8]});
            else if (op != 4'h0)
                e_ill = 1'b1;
            pcm = (pcm + 1) % 256;
            n++;
        end
        e_pc  = pcm;
        e_cnt = n;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    task automatic rand_regs();
        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
    endtask

    function automatic logic [15:0] rand_alu();
        logic [3:0] op;
        case ($urandom_range(0, 3))
            0: op = 4'h1;
            1: op = 4'h2;
            2: op = 4'h4;
            default: op = 4'h8;
        endcase
        return {op, 12'($urandom)};
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
    endtask

    task automatic wait_not_busy(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 3000);
        chk(name, 32'(busy), 32'(0));
    endtask

    task automatic check_end(input string name, input int e_pc, input int e_cnt,
                             input logic e_ill, input logic e_halt);
        chk({name, "_pc"}, 32'(pc), 32'(e_pc));
        chk({name, "_cnt"}, 32'(instr_cnt), 32'(e_cnt));
        chk({name, "_illegal"}, 32'(illegal), 32'(e_ill));
        chk({name, "_halted"}, 32'(halted), 32'(e_halt));
        chk({name, "_pending"}, 32'(exp_q.size()), 32'(0));
    endtask

    task automatic run_prog(input string name, input int max_instr);
        int e_pc, e_cnt;
        logic e_ill, e_halt;
        model(max_instr, e_pc, e_cnt, e_ill, e_halt);
        pulse_start();
        wait_not_busy({name, "_done"});
        check_end(name, e_pc, e_cnt, e_ill, e_halt);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_imem_en"}, 32'(imem_en), 32'(0));
        chk({name, "_busy"}, 32'(busy), 32'(0));
        chk({name, "_halted"}, 32'(halted), 32'(0));
        chk({name, "_illegal"}, 32'(illegal), 32'(0));
        chk({name, "_pc"}, 32'(pc), 32'(0));
        chk({name, "_cnt"}, 32'(instr_cnt), 32'(0));
        chk({name, "_opcode"}, 32'(opcode), 32'(0));
        chk({name, "_dest"}, 32'(destadd), 32'(0));
        chk({name, "_src"}, 32'({src1, src2}), 32'(0));
        chk({name, "_rsadd"}, 32'({rs1_add, rs2_add}), 32'(0));
    endtask

    initial begin
        int n, e_pc, e_cnt, len, snap;
        logic e_ill, e_halt;

        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; halt_req = 1'b0;
        start_b = 1'b0; halt_req_b = 1'b0;
        clear_imem();
        rand_regs();
        for (int i = 0; i < 4; i++) imem_b[i] = {4'h1, 12'($urandom)};
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // ADD r3 = r1 + r2, then HALT; EXEC is 4 cycles after the start cycle.
        regs[1] = 8'd5; regs[2] = 8'd7;
        imem[0] = 16'h1312;
        model(1000, e_pc, e_cnt, e_ill, e_halt);
        pulse_start();
        n = 1;  // the edge that sampled start is already behind us
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (opcode == 4'h0 && n < 20);
        chk("alu_latency", 32'(n), 32'(4));
        wait_not_busy("add_done");
        check_end("add", e_pc, e_cnt, e_ill, e_halt);

        // SUB, NOP, HALT.
        clear_imem();
        imem[0] = 16'h2412; imem[1] = 16'h0000;
        run_prog("sub_nop_halt", 1000);
        chk("sub_nop_halt_busy", 32'(busy), 32'(0));

        // Illegal opcode is sticky until the next start.
        clear_imem();
        imem[0] = 16'h3000;
        run_prog("illegal", 1000);
        imem[0] = 16'h1312;
        model(1000, e_pc, e_cnt, e_ill, e_halt);
        pulse_start();
        @(negedge clk);
        chk("illegal_cleared", 32'(illegal), 32'(0));
        wait_not_busy("illegal2_done");
        check_end("illegal2", e_pc, e_cnt, e_ill, e_halt);

        // HALT first: HALTED appears after FETCH, DECODE, READ.
        clear_imem();
        pulse_start();
        n = 1;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!halted && n < 20);
        chk("halt_latency", 32'(n), 32'(4));

        // Single-step with stray step pulses outside STEP_WAIT.
        clear_imem();
        rand_regs();
        for (int i = 0; i < 3; i++) imem[i] = rand_alu();
        step_mode = 1'b1;
        snap = exec_seen;
        model(1000, e_pc, e_cnt, e_ill, e_halt);
        pulse_start();
        pulse_step();
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            while (instr_cnt != 16'(k) && n < 200) begin
                @(negedge clk); n++;
            end
            chk("step_retired", 32'(instr_cnt), 32'(k));
            repeat (6) @(negedge clk);
            chk("step_parked_execs", 32'(exec_seen - snap), 32'(k));
            chk("step_parked_busy", 32'(busy), 32'(1));
            pulse_step();
            if (k < 3) pulse_step();
        end
        wait_not_busy("step_done");
        check_end("step", e_pc, e_cnt, e_ill, e_halt);

        // halt_req beats step_mode in WB: back to IDLE after one instruction.
        halt_req = 1'b1;
        run_prog("halt_req", 1);
        halt_req = 1'b0;
        step_mode = 1'b0;

        // Random programs; a second start while busy must be ignored.
        for (int t = 0; t < 6; t++) begin
            clear_imem();
            rand_regs();
            len = $urandom_range(2, 10);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 5))
                    0: imem[i] = {4'h0, 12'($urandom)};
                    1: imem[i] = {4'(3 + 2 * $urandom_range(0, 1)), 12'($urandom)};
                    default: imem[i] = rand_alu();
                endcase
            end
            model(1000, e_pc, e_cnt, e_ill, e_halt);
            pulse_start();
            pulse_start();
            wait_not_busy("rand_done");
            check_end("rand", e_pc, e_cnt, e_ill, e_halt);
        end

        // Reset during EXEC aborts at once and nothing executes afterwards.
        clear_imem();
        imem[0] = rand_alu(); imem[1] = rand_alu();
        model(1000, e_pc, e_cnt, e_ill, e_halt);
        pulse_start();
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (opcode == 4'h0 && n < 20);
        chk("reset_test_exec_seen", 32'(opcode != 4'h0), 32'(1));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        snap = exec_seen;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_execs", 32'(exec_seen - snap), 32'(0));
        chk("post_reset_busy", 32'(busy), 32'(0));

        // Small instance: PC wraps 0..3 and the 3-bit counter saturates at 7.
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        n = 0;
        while (n_b < 10 && n < 500) begin
            @(negedge clk); n++;
        end
        halt_req_b = 1'b1;
        chk("b_exec_count", 32'(n_b), 32'(10));
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (busy_b && n < 50);
        halt_req_b = 1'b0;
        chk("b_idle", 32'(busy_b), 32'(0));
        chk("b_final_pc", 32'(pc_b), 32'(2));
        chk("b_final_cnt", 32'(instr_cnt_b), 32'(7));
        chk("b_halted", 32'(halted_b), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
